ts_win_sched: RTL

//   Time-slot window scheduler for the LDPC output bit stream. It counts LDPC info bits and codewords per frame.
//   It asserts ts0_win for the first ts0_ncw codewords, then ts1_win for the next ts1_ncw codewords.

---
 rtl/ts_win_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/ts_win_sched.sv
// Time-slot window scheduler: counts LDPC info bits and codewords per frame and
// raises ts0_win for the first ts0_ncw codewords, then ts1_win for the next ts1_ncw.
module ts_win_sched #(
    parameter int BIT_W = 13,
    parameter int NCW_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_frame_start,
    input  logic             i_ldpc_rate,
    input  logic [NCW_W-1:0] i_ts0_ncw,
    input  logic [NCW_W-1:0] i_ts1_ncw,
    input  logic             i_ldpc_en_out,
    output logic             o_ts0_win,
    output logic             o_ts1_win,
    output logic             o_busy,
    output logic [NCW_W-1:0] o_cw_idx,
    output logic             o_sched_done,
    output logic             o_err_ovr,
    output logic             o_err_stray
);

    typedef enum logic [1:0] {IDLE, TS0, TS1} state_t;

    state_t           r_state;
    logic             r_rate;
    logic [NCW_W-1:0] r_ts0_ncw;
    logic [NCW_W-1:0] r_ts1_ncw;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [NCW_W-1:0] r_cw_idx;
    logic             r_sched_done;
    logic             r_err_ovr;
    logic             r_err_stray;

    logic [BIT_W-1:0] w_kmax;
    logic [NCW_W-1:0] w_ncw;
    logic             w_last_bit;
    logic             w_last_cw;

    assign w_kmax     = r_rate ? BIT_W'(6911) : BIT_W'(4607);
    assign w_ncw      = (r_state == TS1) ? r_ts1_ncw : r_ts0_ncw;
    assign w_last_bit = (r_bit_cnt == w_kmax);
    // w_ncw is never 0 while in TS0/TS1, so the subtraction cannot wrap there
    assign w_last_cw  = (r_cw_idx == w_ncw - NCW_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_rate       <= 1'b0;
            r_ts0_ncw    <= '0;
            r_ts1_ncw    <= '0;
            r_bit_cnt    <= '0;
            r_cw_idx     <= '0;
            r_sched_done <= 1'b0;
            r_err_ovr    <= 1'b0;
            r_err_stray  <= 1'b0;
        end else begin
            r_sched_done <= 1'b0;
            r_err_ovr    <= 1'b0;
            r_err_stray  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bit_cnt   <= '0;
                    r_cw_idx    <= '0;
                    r_err_stray <= i_ldpc_en_out;
                    if (i_frame_start) begin
                        r_rate    <= i_ldpc_rate;
                        r_ts0_ncw <= i_ts0_ncw;
                        r_ts1_ncw <= i_ts1_ncw;
                        if (i_ts0_ncw != '0)      r_state <= TS0;
                        else if (i_ts1_ncw != '0) r_state <= TS1;
                        else                      r_sched_done <= 1'b1;
                    end
                end
                TS0, TS1: begin
                    r_err_ovr <= i_frame_start;
                    if (i_ldpc_en_out) begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (w_last_cw) begin
                                r_cw_idx <= '0;
                                if (r_state == TS0 && r_ts1_ncw != '0) begin
                                    r_state <= TS1;
                                end else begin
                                    r_state      <= IDLE;
                                    r_sched_done <= 1'b1;
                                end
                            end else begin
                                r_cw_idx <= r_cw_idx + NCW_W'(1);
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ts0_win    = (r_state == TS0);
    assign o_ts1_win    = (r_state == TS1);
    assign o_busy       = (r_state != IDLE);
    assign o_cw_idx     = r_cw_idx;
    assign o_sched_done = r_sched_done;
    assign o_err_ovr    = r_err_ovr;
    assign o_err_stray  = r_err_stray;

endmodule
